// File: rtl/sopc_host_if_pkg.sv
// Shared constants and types for the SOPC host interface: reset levels, register offsets, STATUS layout.
package sopc_host_if_pkg;

  localparam logic        RST_ENABLE  = 1'b0;
  localparam logic        RST_DISABLE = 1'b1;
  localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

  // Word offsets within the 16-byte window (addr[3:2]).
  localparam logic [1:0] HOSTIF_TOHOST_OFF  = 2'd0;
  localparam logic [1:0] HOSTIF_CONSOLE_OFF = 2'd1;
  localparam logic [1:0] HOSTIF_STATUS_OFF  = 2'd2;
  localparam logic [1:0] HOSTIF_CYCLE_OFF   = 2'd3;

  typedef struct packed {
    logic [26:0] rsvd;
    logic        full;
    logic        empty;
    logic [2:0]  cnt;
  } status_t;

endpackage

// File: rtl/host_fifo.sv
// Console byte FIFO: power-of-two depth, registered head, push accepted when full only alongside a pop.
module host_fifo
  import sopc_host_if_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic                        do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/sopc_host_if.sv
// SOPC host interface: TOHOST halt/exit code, console byte stream, STATUS and CYCLE registers.
// Optional HOSTIF_CYCLE_CNT_EN adds a 64-bit run-time cycle counter readable at CYCLE.
module sopc_host_if
  import sopc_host_if_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_data_i,
  output logic [31:0] mem_data_o,
  output logic        stall_o,
  output logic        con_valid_o,
  output logic [7:0]  con_data_o,
  input  logic        con_ready_i,
  output logic        halt_o,
  output logic [30:0] exit_code_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          hit, tohost_wr, push_req, push, pop;
  logic          full, empty;
  logic [CW-1:0] count;
  logic [1:0]    off;
  logic [31:0]   cyc_lo;
  status_t       status;
  logic [4:0]    unused_bits;

  assign hit       = mem_ce_i & (mem_addr_i[31:4] == BASE_ADDR[31:4]);
  assign off       = mem_addr_i[3:2];
  assign tohost_wr = hit & mem_we_i & (off == HOSTIF_TOHOST_OFF);
  assign push_req  = hit & mem_we_i & (off == HOSTIF_CONSOLE_OFF) & mem_sel_i[0];
  assign pop       = con_valid_o & con_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO only stalls without one.
  assign stall_o   = push_req & full & ~pop;
  assign push      = push_req & ~stall_o;
  assign con_valid_o = ~empty;
  assign unused_bits = {mem_addr_i[1:0], mem_sel_i[3:1]};

  host_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (mem_data_i[7:0]),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .count (count),
    .head  (con_data_o)
  );

  // First exit code wins; halt stays set until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      halt_o      <= 1'b0;
      exit_code_o <= '0;
    end else if (tohost_wr & mem_data_i[0] & ~halt_o) begin
      halt_o      <= 1'b1;
      exit_code_o <= mem_data_i[31:1];
    end
  end

`ifdef HOSTIF_CYCLE_CNT_EN
  logic [63:0] cyc;
  logic [31:0] unused_cyc_hi;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) cyc <= '0;
    else if (~halt_o)      cyc <= cyc + 64'd1;
  end

  assign cyc_lo        = cyc[31:0];
  assign unused_cyc_hi = cyc[63:32];
`else
  assign cyc_lo = ZERO_WORD;
`endif

  // Count field is the low three bits of the occupancy, so a full 8-deep FIFO reads 0 there.
  assign status = '{rsvd: '0, full: full, empty: empty, cnt: 3'(count)};

  always_comb begin
    mem_data_o = ZERO_WORD;
    if (hit & ~mem_we_i) begin
      case (off)
        HOSTIF_TOHOST_OFF: mem_data_o = {exit_code_o, halt_o};
        HOSTIF_STATUS_OFF: mem_data_o = status;
        HOSTIF_CYCLE_OFF:  mem_data_o = cyc_lo;
        default:           mem_data_o = ZERO_WORD;
      endcase
    end
  end

endmodule

// File: tb/tb_sopc_host_if.sv
// Scoreboard bench for sopc_host_if: queue-based reference model, decoupled console monitor.
module tb_sopc_host_if;

  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_ce_i = 1'b0, mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0, mem_data_i = '0;
  logic [3:0]  mem_sel_i = '0;
  logic [31:0] mem_data_o;
  logic        stall_o, con_valid_o, con_ready_i = 1'b0, halt_o;
  logic [7:0]  con_data_o;
  logic [30:0] exit_code_o;

  always #5 clk = ~clk;

  sopc_host_if #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_sel_i(mem_sel_i), .mem_data_i(mem_data_i), .mem_data_o(mem_data_o),
    .stall_o(stall_o), .con_valid_o(con_valid_o), .con_data_o(con_data_o),
    .con_ready_i(con_ready_i), .halt_o(halt_o), .exit_code_o(exit_code_o)
  );

  int total = 0, bad = 0;

  // Reference model state
  logic [7:0]      exp_q[$];
  int              model_cnt = 0;
  logic            model_halt = 1'b0;
  logic [30:0]     model_code = '0;
  longint unsigned model_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Console monitor: every byte handed over must be the next one the model accepted.
  always @(negedge clk) begin
    if (rst) begin
      chk("con_valid", 64'(con_valid_o), 64'(model_cnt != 0));
      if (con_valid_o && con_ready_i) begin
        if (exp_q.size() == 0) chk("con_unexpected_byte", 64'(con_data_o), 64'hFFFF);
        else chk("con_data", 64'(con_data_o), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic step(input logic ce, input logic we, input logic [31:0] addr,
                      input logic [3:0] sel, input logic [31:0] data, input logic rdy);
    logic       hit, pop, full, push_req, stall_exp, push_acc;
    logic [1:0] off;
    logic [31:0] rd_exp;
    mem_ce_i = ce; mem_we_i = we; mem_addr_i = addr;
    mem_sel_i = sel; mem_data_i = data; con_ready_i = rdy;
    #1;
    hit       = ce && (addr[31:4] == BASE[31:4]);
    off       = addr[3:2];
    pop       = (model_cnt > 0) && rdy;
    full      = (model_cnt == DEPTH);
    push_req  = hit && we && (off == 2'd1) && sel[0];
    stall_exp = push_req && full && !pop;
    chk("stall", 64'(stall_o), 64'(stall_exp));
    if (!(hit && we)) begin
      rd_exp = 32'h0;
      if (hit) begin
        case (off)
          2'd0: rd_exp = {model_code, model_halt};
          2'd2: rd_exp = {27'd0, full, model_cnt == 0, 3'(model_cnt)};
`ifdef HOSTIF_CYCLE_CNT_EN
          2'd3: rd_exp = model_cyc[31:0];
`endif
          default: rd_exp = 32'h0;
        endcase
      end
      chk("rdata", 64'(mem_data_o), 64'(rd_exp));
    end
    @(posedge clk);
    push_acc = push_req && !stall_exp;
    if (push_acc) exp_q.push_back(data[7:0]);
    model_cnt = model_cnt + int'(push_acc) - int'(pop);
    if (!model_halt) model_cyc++;
    if (hit && we && off == 2'd0 && data[0] && !model_halt) begin
      model_halt = 1'b1;
      model_code = data[31:1];
    end
    #1;
    chk("halt", 64'(halt_o), 64'(model_halt));
    chk("exit_code", 64'(exit_code_o), 64'(model_code));
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic r);
    step(1'b1, 1'b1, a, s, d, r);
  endtask

  task automatic rd(input logic [31:0] a, input logic r);
    step(1'b1, 1'b0, a, 4'hF, 32'h0, r);
  endtask

  task automatic idle(input logic r);
    step(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, r);
  endtask

  initial begin
    logic [31:0] a, d;
    int k;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(con_valid_o), 64'd0);
    chk("rst_halt", 64'(halt_o), 64'd0);
    chk("rst_code", 64'(exit_code_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    rst = 1'b1;
    model_cyc = 0;
    rd(BASE + 32'h8, 1'b0);

    // Console: 'A' then 'B' streamed with ready high
    wr(BASE + 32'h4, 32'h41, 4'hF, 1'b1);
    wr(BASE + 32'h4, 32'h42, 4'hF, 1'b1);
    repeat (3) idle(1'b1);

    // Fill, then overflow write stalls until the consumer pops
    for (int i = 0; i < DEPTH; i++) wr(BASE + 32'h4, 32'h60 + i, 4'hF, 1'b0);
    wr(BASE + 32'h4, 32'h70, 4'hF, 1'b0);
    wr(BASE + 32'h4, 32'h70, 4'hF, 1'b0);
    rd(BASE + 32'h8, 1'b0);
    wr(BASE + 32'h4, 32'h70, 4'hF, 1'b1);
    repeat (10) idle(1'b1);

    // Halt semantics
    wr(BASE, 32'h2, 4'hF, 1'b1);
    rd(BASE, 1'b1);
    wr(BASE, 32'h7, 4'hF, 1'b1);
    chk("exit_code_is_3", 64'(exit_code_o), 64'd3);
    wr(BASE, 32'h5, 4'hF, 1'b1);
    chk("exit_code_kept", 64'(exit_code_o), 64'd3);
    rd(BASE, 1'b1);

    // Lane and decode boundaries
    wr(BASE + 32'h4, 32'h55, 4'b1110, 1'b1);
    wr(BASE + 32'h14, 32'h77, 4'hF, 1'b1);
    rd(BASE + 32'h10, 1'b1);
    rd(BASE + 32'h8, 1'b1);
    rd(BASE + 32'hC, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 5);
      a = (k == 5) ? $urandom : BASE + 32'(k * 4);
      d = $urandom;
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), a,
           4'($urandom), d, 1'($urandom_range(0, 2) == 0));
    end

    // Async reset mid-stream with bytes queued
    while (model_cnt > 0) idle(1'b1);
    for (int i = 0; i < 3; i++) wr(BASE + 32'h4, 32'h30 + i, 4'hF, 1'b0);
    rst = 1'b0;
    #1;
    chk("arst_valid", 64'(con_valid_o), 64'd0);
    chk("arst_halt", 64'(halt_o), 64'd0);
    chk("arst_code", 64'(exit_code_o), 64'd0);
    chk("arst_stall", 64'(stall_o), 64'd0);
    exp_q.delete();
    model_cnt = 0; model_halt = 1'b0; model_code = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_cyc = 0;
    rd(BASE + 32'h8, 1'b0);

    // Cycle counter runs until halt, then freezes
    repeat (99) idle(1'b0);
    rd(BASE + 32'hC, 1'b0);
    wr(BASE, 32'h9, 4'hF, 1'b0);
    repeat (5) idle(1'b0);
    rd(BASE + 32'hC, 1'b0);
    wr(BASE + 32'h4, 32'h5A, 4'hF, 1'b1);

    // Bounded drain: every accepted byte must come out
    k = 0;
    while (exp_q.size() > 0 && k < 20) begin
      idle(1'b1);
      k++;
    end
    chk("drain_left", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
